// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, fetch defaults and the NOP encoding
// shown on the decode port while no instruction is available.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP_DEF = 4;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction SRAM request/response plus the decode handshake.
// Handshake: a beat transfers on a cycle where id_valid & id_ready are both high;
// id_valid never depends on id_ready, and the payload holds stable while id_valid & ~id_ready.
interface fetch_unit_if #(
  parameter int DATA_W = cpu_pkg::INSTR_W
);

  logic [DATA_W-1:0] imem_addr;
  logic              imem_ren;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instruction;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_updated_pc;

  modport master (
    output imem_addr, imem_ren, id_valid, id_instruction, id_pc, id_updated_pc,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_addr, imem_ren, id_valid, id_instruction, id_pc, id_updated_pc,
    output imem_rdata, id_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; no bypass, so a push is visible
// at the head only from the cycle after it is written.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues SRAM reads under a credit
// limit, and buffers returned words in a prefetch FIFO feeding decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH = 4,
  parameter int PC_STEP = PC_STEP_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  fetch_unit_if.master      bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   tag_pc;
  logic                inflight;
  logic                kill;
  logic                issue;
  logic                push;
  logic                pop;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] head;
  logic [CW:0]         in_use;
  logic [DATA_W-1:0]   head_instr;
  logic [DATA_W-1:0]   head_pc;

  // Buffered plus inflight words may never exceed DEPTH, so a return always has a slot.
  // Gating with arst_n keeps the request line quiet while reset is held.
  assign in_use = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign issue  = arst_n & enable & ~redirect & (in_use < (CW+1)'(DEPTH));
  assign push   = inflight & ~kill & ~redirect;
  assign pop    = ~fifo_empty & bus.id_ready & ~redirect;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= redirect & inflight;
      if (issue) tag_pc <= pc;
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + DATA_W'(PC_STEP);
    end
  end

  sync_fifo #(
    .WIDTH(2*DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(arst_n),
    .push (push),
    .pop  (pop),
    .clear(redirect),
    .wdata({bus.imem_rdata, tag_pc}),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head_instr = head[2*DATA_W-1:DATA_W];
  assign head_pc    = head[DATA_W-1:0];

  assign bus.imem_addr      = pc;
  assign bus.imem_ren       = issue;
  assign bus.id_valid       = ~fifo_empty;
  assign bus.id_instruction = fifo_empty ? NOP : head_instr;
  assign bus.id_pc          = fifo_empty ? '0 : head_pc;
  assign bus.id_updated_pc  = fifo_empty ? '0 : head_pc + DATA_W'(PC_STEP);

  no_push_when_full: assert property (@(posedge clk) disable iff (!arst_n) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected decode beats are queued when stimulus
// is applied and popped by a monitor whenever a beat is accepted.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int W = 96;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        arst2_n;
  logic        enable2;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_beat;
  logic [W-1:0] exp_beat;
  int checks  = 0;
  int errors  = 0;
  int beats   = 0;
  int ren_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_W(32)) bus ();
  fetch_unit_if #(.DATA_W(32)) bus2 ();

  fetch_unit #(.DATA_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(bus)
  );

  fetch_unit #(.DATA_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .arst_n(arst2_n), .enable(enable2), .redirect(1'b0),
    .redirect_pc(32'h0), .bus(bus2)
  );

  // SRAM models: word at byte address a holds a/4, one-cycle read latency.
  always @(posedge clk) if (bus.imem_ren) bus.imem_rdata <= bus.imem_addr >> 2;
  always @(posedge clk) if (bus2.imem_ren) bus2.imem_rdata <= bus2.imem_addr >> 2;

  function automatic logic [W-1:0] entry(logic [31:0] a);
    logic [31:0] w;
    logic [31:0] u;
    w = a >> 2;
    u = a + 32'd4;
    return {a, w, u};
  endfunction

  task automatic refill(logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(entry(base + 32'(4 * i)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: a beat is accepted when valid & ready outside a redirect cycle.
  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.imem_ren) ren_cnt++;
      if (bus.id_valid && bus.id_ready && !redirect) begin
        beats++;
        got_beat = {bus.id_pc, bus.id_instruction, bus.id_updated_pc};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL beat_unexpected observed=%h expected=none", got_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          assert (got_beat === exp_beat) else begin
            errors++;
            $error("FAIL beat observed=%h expected=%h", got_beat, exp_beat);
          end
        end
      end
    end
  end

  task automatic start(logic rdy);
    arst_n = 1'b0;
    redirect = 1'b0;
    enable = 1'b1;
    bus.id_ready = rdy;
    tick();
    tick();
    refill(32'h0);
    beats = 0;
    ren_cnt = 0;
    arst_n = 1'b1;
  endtask

  task automatic wait_beats(string tag, int n);
    for (int i = 0; i < 200 && beats < n; i++) tick();
    check(tag, W'(beats >= n), W'(1));
  endtask

  initial begin
    arst_n = 1'b0;
    arst2_n = 1'b0;
    enable = 1'b1;
    enable2 = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    bus.id_ready = 1'b1;
    bus2.id_ready = 1'b1;

    // Reset values while reset is held with enable high.
    tick();
    tick();
    check("rst_valid", W'(bus.id_valid), W'(0));
    check("rst_ren", W'(bus.imem_ren), W'(0));
    check("rst_addr", W'(bus.imem_addr), W'(32'h0));
    check("rst_data", {bus.id_pc, bus.id_instruction, bus.id_updated_pc}, W'(0));

    // Streaming from reset: id_valid rises in cycle 2.
    refill(32'h0);
    beats = 0;
    arst_n = 1'b1;
    #1;
    check("c0_ren", W'(bus.imem_ren), W'(1));
    check("c0_valid", W'(bus.id_valid), W'(0));
    tick();
    check("c1_valid", W'(bus.id_valid), W'(0));
    check("c1_addr", W'(bus.imem_addr), W'(32'h4));
    tick();
    check("c2_valid", W'(bus.id_valid), W'(1));
    check("c2_pc", W'(bus.id_pc), W'(32'h0));
    wait_beats("stream_beats", 10);

    // Back-pressure: four requests fill the FIFO, head holds pc 0.
    start(1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("bp_ren_cnt", W'(ren_cnt), W'(4));
    check("bp_ren_low", W'(bus.imem_ren), W'(0));
    check("bp_head_pc", W'(bus.id_pc), W'(32'h0));
    check("bp_valid", W'(bus.id_valid), W'(1));
    bus.id_ready = 1'b1;
    wait_beats("bp_drain", 12);

    // Redirect with three entries buffered and one inflight.
    start(1'b0);
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    refill(32'h100);
    #1;
    check("rd_ren", W'(bus.imem_ren), W'(0));
    tick();
    redirect = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    check("rd_valid_r1", W'(bus.id_valid), W'(0));
    check("rd_addr_r1", W'(bus.imem_addr), W'(32'h100));
    tick();
    check("rd_valid_r2", W'(bus.id_valid), W'(0));
    tick();
    check("rd_valid_r3", W'(bus.id_valid), W'(1));
    check("rd_pc_r3", W'(bus.id_pc), W'(32'h100));
    beats = 0;
    wait_beats("rd_beats", 6);

    // Redirect while a beat is offered and accepted: that pop is discarded.
    check("rp_valid", W'(bus.id_valid), W'(1));
    redirect = 1'b1;
    redirect_pc = 32'h200;
    refill(32'h200);
    tick();
    redirect = 1'b0;
    #1;
    check("rp_valid_r1", W'(bus.id_valid), W'(0));
    beats = 0;
    wait_beats("rp_beats", 6);

    // Back-to-back redirects: the last target wins.
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    refill(32'h400);
    tick();
    redirect = 1'b0;
    beats = 0;
    wait_beats("b2b_beats", 5);

    // enable drops with one request inflight.
    start(1'b0);
    tick();
    enable = 1'b0;
    #1;
    check("en_ren_off", W'(bus.imem_ren), W'(0));
    for (int i = 0; i < 4; i++) tick();
    check("en_addr_hold", W'(bus.imem_addr), W'(32'h4));
    check("en_captured", W'(bus.id_valid), W'(1));
    check("en_head_pc", W'(bus.id_pc), W'(32'h0));
    check("en_ren_cnt", W'(ren_cnt), W'(1));
    enable = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    check("en_resume_addr", W'(bus.imem_addr), W'(32'h4));
    wait_beats("en_beats", 6);

    // PC wrap on the second instance, then a mid-stream reset pulse.
    arst_n = 1'b0;
    enable2 = 1'b1;
    tick();
    arst2_n = 1'b1;
    #1;
    check("wr_addr0", W'(bus2.imem_addr), W'(32'hFFFF_FFF8));
    tick();
    check("wr_addr1", W'(bus2.imem_addr), W'(32'hFFFF_FFFC));
    tick();
    check("wr_addr2", W'(bus2.imem_addr), W'(32'h0000_0000));
    check("wr_beat0", {bus2.id_pc, bus2.id_instruction, bus2.id_updated_pc}, entry(32'hFFFF_FFF8));
    tick();
    check("wr_addr3", W'(bus2.imem_addr), W'(32'h0000_0004));
    check("wr_beat1", {bus2.id_pc, bus2.id_instruction, bus2.id_updated_pc}, entry(32'hFFFF_FFFC));
    tick();
    check("wr_beat2", {bus2.id_pc, bus2.id_instruction, bus2.id_updated_pc}, entry(32'h0));
    arst2_n = 1'b0;
    #1;
    check("ar_valid", W'(bus2.id_valid), W'(0));
    check("ar_ren", W'(bus2.imem_ren), W'(0));
    check("ar_addr", W'(bus2.imem_addr), W'(32'hFFFF_FFF8));
    check("ar_data", {bus2.id_pc, bus2.id_instruction, bus2.id_updated_pc}, W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
